// File: rtl/chip_shiftreg_checker.sv
`default_nettype none
// ============================================================================
//  Module      : chip_shiftreg_checker
//  Description : Board-level tester for universal bidirectional shift-register
//                chips (74194 at WIDTH=4, 74299-class at WIDTH=8). A rising
//                edge on Run clears the chip, then applies NUM_VECTORS
//                LFSR-derived vectors (hold / shift right / shift left / load).
//                After each vector it compares the synchronised chip outputs
//                with an internal reference model.
//  Ports       : Clk, Reset         - system clock, synchronous active-high reset
//                Run, DISP_RSLT     - run request (edge), result display gate
//                dut_clr_n, dut_s, dut_sr, dut_sl, dut_par, dut_clk
//                                   - registered chip drives
//                dut_q              - chip outputs (asynchronous, synchronised here)
//                Done, RSLT         - run complete, gated pass flag
//                err_count          - saturating count of mismatching vectors
//                first_fail         - first mismatching vector index (FFFF = none)
//  Revision    : 1.0 - initial release
// ============================================================================
module chip_shiftreg_checker #(
    parameter int          WIDTH       = 4,
    parameter int          NUM_VECTORS = 64,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          CLK_HI_CYC  = 4,
    parameter int          SETTLE_CYC  = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          CLR_EVERY   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             DISP_RSLT,
    output logic             dut_clr_n,
    output logic [1:0]       dut_s,
    output logic             dut_sr,
    output logic             dut_sl,
    output logic [WIDTH-1:0] dut_par,
    output logic             dut_clk,
    input  logic [WIDTH-1:0] dut_q,
    output logic             Done,
    output logic             RSLT,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int          c_ST_W     = 3;
    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_CLEAR    = 3'd1;
    localparam logic [2:0]  c_SETUP    = 3'd2;
    localparam logic [2:0]  c_CLK_HI   = 3'd3;
    localparam logic [2:0]  c_CLK_LO   = 3'd4;
    localparam logic [2:0]  c_CHECK    = 3'd5;
    localparam logic [2:0]  c_DONE     = 3'd6;

    localparam logic [15:0] c_CLR_LAST = 16'd1;                      // 2-cycle clear
    localparam logic [15:0] c_HI_LAST  = 16'(CLK_HI_CYC - 1);
    localparam logic [15:0] c_LO_LAST  = 16'(SETTLE_CYC + SYNC_STAGES - 1);
    localparam logic [15:0] c_LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] c_TAPS     = 16'hB400;                   // x^16+x^14+x^13+x^11
    localparam logic        c_CLR_EN   = (CLR_EVERY != 0);
    localparam logic [15:0] c_CLR_WRAP = 16'((CLR_EVERY > 0) ? CLR_EVERY - 1 : 0);
    localparam logic [15:0] c_NONE     = 16'hFFFF;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_next;
    logic [15:0]       r_cnt;
    logic              r_run_q;
    logic              r_run_prev;
    logic [15:0]       r_lfsr;
    logic [15:0]       r_idx;
    logic [15:0]       r_clr_phase;      // index modulo CLR_EVERY, kept incrementally
    logic              r_clr_vec;        // current vector is a clear vector
    logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]  r_model;
    logic [15:0]       r_err;
    logic [15:0]       r_first;
    logic              r_done;
    logic              r_clr_n;
    logic [1:0]        r_s;
    logic              r_sr;
    logic              r_sl;
    logic [WIDTH-1:0]  r_par;
    logic              r_dclk;

    logic              w_run_edge;
    logic [15:0]       w_lfsr_adv;
    logic [WIDTH-1:0]  w_q_sync;
    logic              w_mismatch;
    logic              w_last;
    logic              w_load;
    logic [15:0]       w_vec_lfsr;
    logic [15:0]       w_vec_idx;
    logic [15:0]       w_vec_phase;
    logic              w_vec_clr;
    logic [WIDTH-1:0]  w_vec_par;
    logic [WIDTH-1:0]  w_model_next;

    assign w_run_edge = r_run_q & ~r_run_prev;
    assign w_lfsr_adv = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);
    assign w_q_sync   = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_q_sync != r_model);
    assign w_last     = (r_idx == c_LAST_IDX);

    // New vector drives are registered on entry to SETUP, one cycle ahead
    // of the chip clock edge, so the chip sees stable data at its edge.
    assign w_load      = ((r_state == c_CLEAR) && (w_state_next == c_SETUP)) ||
                         ((r_state == c_CHECK) && !w_last);
    assign w_vec_lfsr  = (r_state == c_CHECK) ? w_lfsr_adv : r_lfsr;
    assign w_vec_idx   = (r_state == c_CHECK) ? (r_idx + 16'd1) : r_idx;
    assign w_vec_phase = (r_state != c_CHECK)        ? 16'd0 :
                         (r_clr_phase == c_CLR_WRAP) ? 16'd0 : (r_clr_phase + 16'd1);
    assign w_vec_clr   = c_CLR_EN && (w_vec_phase == 16'd0) && (w_vec_idx != 16'd0);

    // Parallel data field starts at LFSR bit 4 and wraps around the 16-bit word.
    always_comb begin
        w_vec_par = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_vec_par[i] = w_vec_lfsr[4'((i + 4) % 16)];
        end
    end

    // Reference chip behaviour for the vector currently on the pins.
    always_comb begin
        w_model_next = r_model;
        if (r_clr_vec) begin
            w_model_next = '0;
        end else begin
            case (r_s)
                2'b01:   w_model_next = {r_model[WIDTH-2:0], r_sr};
                2'b10:   w_model_next = {r_sl, r_model[WIDTH-1:1]};
                2'b11:   w_model_next = r_par;
                default: w_model_next = r_model;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_run_edge)             w_state_next = c_CLEAR;
            c_CLEAR:  if (r_cnt == c_CLR_LAST)    w_state_next = c_SETUP;
            c_SETUP:                              w_state_next = c_CLK_HI;
            c_CLK_HI: if (r_cnt == c_HI_LAST)     w_state_next = c_CLK_LO;
            c_CLK_LO: if (r_cnt == c_LO_LAST)     w_state_next = c_CHECK;
            c_CHECK:  w_state_next = w_last ? c_DONE : c_SETUP;
            c_DONE:   if (!r_run_q)               w_state_next = c_IDLE;
            default:                              w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_run_q     <= 1'b0;
            r_run_prev  <= 1'b0;
            r_cnt       <= '0;
            r_lfsr      <= SEED;
            r_idx       <= '0;
            r_clr_phase <= '0;
            r_clr_vec   <= 1'b0;
            r_model     <= '0;
            r_err       <= '0;
            r_first     <= c_NONE;
            r_done      <= 1'b0;
            r_clr_n     <= 1'b1;
            r_s         <= '0;
            r_sr        <= 1'b0;
            r_sl        <= 1'b0;
            r_par       <= '0;
            r_dclk      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_run_q    <= Run;
            r_run_prev <= r_run_q;
            r_sync[0]  <= dut_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_cnt <= (w_state_next != r_state) ? '0 : (r_cnt + 16'd1);

            case (r_state)
                c_IDLE: begin
                    if (w_run_edge) begin
                        r_lfsr      <= SEED;
                        r_idx       <= '0;
                        r_clr_phase <= '0;
                        r_err       <= '0;
                        r_first     <= c_NONE;
                        r_model     <= '0;
                        r_clr_n     <= 1'b0;
                    end
                end
                c_CLEAR: begin
                    r_model <= '0;
                end
                c_SETUP: begin
                    // Clear vectors rely on CLR alone; the chip is not clocked.
                    r_model <= w_model_next;
                    r_dclk  <= ~r_clr_vec;
                end
                c_CLK_HI: begin
                    if (w_state_next != c_CLK_HI) begin
                        r_dclk <= 1'b0;
                    end
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err != 16'hFFFF) begin
                            r_err <= r_err + 16'd1;
                        end
                        if (r_first == c_NONE) begin
                            r_first <= r_idx;
                        end
                    end
                    r_lfsr      <= w_lfsr_adv;
                    r_idx       <= w_vec_idx;
                    r_clr_phase <= w_vec_phase;
                    if (w_last) begin
                        r_done    <= 1'b1;
                        r_clr_n   <= 1'b1;
                        r_clr_vec <= 1'b0;
                        r_s       <= '0;
                        r_sr      <= 1'b0;
                        r_sl      <= 1'b0;
                        r_par     <= '0;
                    end
                end
                c_DONE: begin
                    if (!r_run_q) begin
                        r_done <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_load) begin
                r_s       <= w_vec_lfsr[1:0];
                r_sr      <= w_vec_lfsr[2];
                r_sl      <= w_vec_lfsr[3];
                r_par     <= w_vec_par;
                r_clr_vec <= w_vec_clr;
                r_clr_n   <= ~w_vec_clr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dut_clr_n  = r_clr_n;
    assign dut_s      = r_s;
    assign dut_sr     = r_sr;
    assign dut_sl     = r_sl;
    assign dut_par    = r_par;
    assign dut_clk    = r_dclk;
    assign Done       = r_done;
    assign err_count  = r_err;
    assign first_fail = r_first;
    assign RSLT       = r_done & DISP_RSLT & (r_err == 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_chip_shiftreg_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip_shiftreg_checker
//  Description : Self-checking bench for chip_shiftreg_checker with an 8-bit
//                behavioural shift-register chip (optionally faulty: QC stuck
//                at 0, or SR/SL swapped). Expected drives, counters and
//                results come from a vector-level model built from the
//                LFSR and mode rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_shiftreg_checker;

    localparam int W  = 8;
    localparam int N  = 256;
    localparam int H  = 4;
    localparam int S  = 4;
    localparam int Y  = 2;
    localparam int CE = 16;
    localparam int P  = 2 + H + S + Y;       // cycles per vector
    localparam int T_DONE = 3 + N * P;       // cycles from Run sample to DONE

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Run;
    logic         DISP_RSLT;
    logic         dut_clr_n;
    logic [1:0]   dut_s;
    logic         dut_sr;
    logic         dut_sl;
    logic [W-1:0] dut_par;
    logic         dut_clk;
    logic [W-1:0] dut_q;
    logic         Done;
    logic         RSLT;
    logic [15:0]  err_count;
    logic [15:0]  first_fail;

    chip_shiftreg_checker #(
        .WIDTH(W), .NUM_VECTORS(N), .SEED(16'hACE1), .CLK_HI_CYC(H),
        .SETTLE_CYC(S), .SYNC_STAGES(Y), .CLR_EVERY(CE)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .DISP_RSLT(DISP_RSLT),
        .dut_clr_n(dut_clr_n), .dut_s(dut_s), .dut_sr(dut_sr), .dut_sl(dut_sl),
        .dut_par(dut_par), .dut_clk(dut_clk), .dut_q(dut_q), .Done(Done),
        .RSLT(RSLT), .err_count(err_count), .first_fail(first_fail)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural chip (with optional fault) ----------------
    int           fault = 0;
    logic [W-1:0] chip_q;

    always @(posedge dut_clk or negedge dut_clr_n) begin
        if (!dut_clr_n) chip_q <= '0;
        else begin
            case (dut_s)
                2'b01: chip_q <= {chip_q[W-2:0], (fault == 2) ? dut_sl : dut_sr};
                2'b10: chip_q <= {(fault == 2) ? dut_sr : dut_sl, chip_q[W-1:1]};
                2'b11: chip_q <= dut_par;
                default: ;
            endcase
        end
    end
    assign dut_q = (fault == 1) ? (chip_q & ~W'(4)) : chip_q;

    // ---------------- vector-level reference model ----------------
    logic [1:0]   v_s   [N];
    logic         v_sr  [N];
    logic         v_sl  [N];
    logic         v_clr [N];
    logic [W-1:0] v_par [N];
    logic [W-1:0] v_exp [N];
    int           pre_err   [N+1];
    logic [15:0]  pre_first [N+1];

    int n_checks = 0;
    int n_fail   = 0;
    int mode_cnt [4];
    bit count_modes = 0;
    int tog_lo = -1;
    int tog_hi = -1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Mode rules written arithmetically: right shift = q*2+SR, left = q/2 + SL*2^(W-1).
    function automatic logic [W-1:0] next_q(input logic [W-1:0] q, input logic [1:0] s,
                                            input logic sr, input logic sl,
                                            input logic [W-1:0] par);
        int qi;
        qi = int'(q);
        case (s)
            2'b00:   return q;
            2'b01:   return W'((qi * 2 + int'(sr)) % (1 << W));
            2'b10:   return W'(qi / 2 + int'(sl) * (1 << (W - 1)));
            default: return par;
        endcase
    endfunction

    task automatic build_model();
        logic [15:0]  lf;
        logic [W-1:0] q;
        lf = 16'hACE1;
        q  = '0;
        for (int v = 0; v < N; v++) begin
            v_s[v]   = lf[1:0];
            v_sr[v]  = lf[2];
            v_sl[v]  = lf[3];
            for (int b = 0; b < W; b++) v_par[v][b] = lf[(4 + b) % 16];
            v_clr[v] = (v % CE == 0) && (v != 0);
            q = v_clr[v] ? '0 : next_q(q, v_s[v], v_sr[v], v_sl[v], v_par[v]);
            v_exp[v] = q;
            lf = lfsr_step(lf);
        end
    endtask

    task automatic build_obs(input int f);
        logic [W-1:0] fq, obs;
        int           e;
        logic [15:0]  ff;
        fq = '0; e = 0; ff = 16'hFFFF;
        for (int v = 0; v < N; v++) begin
            pre_err[v]   = e;
            pre_first[v] = ff;
            if (v_clr[v]) fq = '0;
            else fq = next_q(fq, v_s[v], (f == 2) ? v_sl[v] : v_sr[v],
                             (f == 2) ? v_sr[v] : v_sl[v], v_par[v]);
            if (f == 1)      obs = v_exp[v] & ~W'(4);
            else if (f == 2) obs = fq;
            else             obs = v_exp[v];
            if (obs != v_exp[v]) begin
                e++;
                if (ff == 16'hFFFF) ff = 16'(v);
            end
        end
        pre_err[N]   = e;
        pre_first[N] = ff;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_idle_drives(input string tag);
        chk({tag, "_clr_n"}, 32'(dut_clr_n), 1);
        chk({tag, "_clk"},   32'(dut_clk), 0);
        chk({tag, "_s"},     32'(dut_s), 0);
        chk({tag, "_sr"},    32'(dut_sr), 0);
        chk({tag, "_sl"},    32'(dut_sl), 0);
        chk({tag, "_par"},   32'(dut_par), 0);
    endtask

    // Expected outputs t cycles after the edge that sampled Run high.
    task automatic check_cycle(input int t);
        int   v, j;
        logic eclk;
        if (t < 3) begin
            chk("clear_clr_n", 32'(dut_clr_n), 0);
            chk("clear_clk",   32'(dut_clk), 0);
            chk("clear_done",  32'(Done), 0);
            chk("start_err",   32'(err_count), 0);
            chk("start_first", 32'(first_fail), 32'hFFFF);
        end else if (t < T_DONE) begin
            v = (t - 3) / P;
            j = (t - 3) % P;
            eclk = (j >= 1) && (j <= H) && !v_clr[v];
            chk("vec_s",     32'(dut_s), 32'(v_s[v]));
            chk("vec_sr",    32'(dut_sr), 32'(v_sr[v]));
            chk("vec_sl",    32'(dut_sl), 32'(v_sl[v]));
            chk("vec_par",   32'(dut_par), 32'(v_par[v]));
            chk("vec_clr_n", 32'(dut_clr_n), 32'(!v_clr[v]));
            chk("vec_clk",   32'(dut_clk), 32'(eclk));
            chk("vec_done",  32'(Done), 0);
            chk("run_err",   32'(err_count), 32'(pre_err[v]));
            chk("run_first", 32'(first_fail), 32'(pre_first[v]));
            if (count_modes && j == 1) mode_cnt[dut_s]++;
        end else begin
            chk("done_flag",  32'(Done), 1);
            chk_idle_drives("done");
            chk("done_err",   32'(err_count), 32'(pre_err[N]));
            chk("done_first", 32'(first_fail), 32'(pre_first[N]));
            chk("done_rslt",  32'(RSLT), 32'(DISP_RSLT && pre_err[N] == 0));
        end
    endtask

    // One run; abort_t > 0 asserts Reset at that cycle instead of finishing.
    task automatic do_run(input int f, input int abort_t);
        fault = f;
        build_obs(f);
        @(negedge Clk);
        Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        for (int t = 1; t <= T_DONE; t++) begin
            @(negedge Clk);
            check_cycle(t);
            if (t == tog_lo) Run = 1'b0;
            if (t == tog_hi) Run = 1'b1;
            if (t == abort_t) begin
                Reset = 1'b1;
                Run   = 1'b0;
                @(negedge Clk);
                chk("abort_done",  32'(Done), 0);
                chk("abort_rslt",  32'(RSLT), 0);
                chk("abort_err",   32'(err_count), 0);
                chk("abort_first", 32'(first_fail), 32'hFFFF);
                chk_idle_drives("abort");
                Reset = 1'b0;
                return;
            end
        end
    endtask

    task automatic end_run();
        bit fell;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("hold_done",  32'(Done), 1);
            chk("hold_clr_n", 32'(dut_clr_n), 1);
            chk("hold_clk",   32'(dut_clk), 0);
        end
        DISP_RSLT = 1'b0;
        #1 chk("rslt_disp0", 32'(RSLT), 0);
        DISP_RSLT = 1'b1;
        #1 chk("rslt_disp1", 32'(RSLT), 32'(pre_err[N] == 0));
        Run  = 1'b0;
        fell = 0;
        for (int i = 0; i < 6 && !fell; i++) begin
            @(negedge Clk);
            if (!Done) fell = 1;
        end
        chk("done_falls", 32'(fell), 1);
        repeat (3) @(negedge Clk);
        chk("idle_err",   32'(err_count), 32'(pre_err[N]));
        chk("idle_first", 32'(first_fail), 32'(pre_first[N]));
        chk("idle_rslt",  32'(RSLT), 0);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; DISP_RSLT = 1'b1;
        for (int m = 0; m < 4; m++) mode_cnt[m] = 0;
        build_model();

        // Model pinned against hand-computed values.
        chk("pin_lfsr1", 32'(lfsr_step(16'hACE1)), 32'hE270);
        chk("pin_s0",    32'(v_s[0]), 1);
        chk("pin_par0",  32'(v_par[0]), 32'hCE);
        chk("pin_par1",  32'(v_par[1]), 32'h27);
        chk("pin_exp0",  32'(v_exp[0]), 0);
        chk("pin_clr0",  32'(v_clr[0]), 0);
        chk("pin_clr16", 32'(v_clr[16]), 1);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_done",  32'(Done), 0);
        chk("rst_rslt",  32'(RSLT), 0);
        chk("rst_err",   32'(err_count), 0);
        chk("rst_first", 32'(first_fail), 32'hFFFF);
        chk_idle_drives("rst");
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Clean run with mode statistics.
        count_modes = 1;
        do_run(0, 0);
        count_modes = 0;
        for (int m = 0; m < 4; m++) chk("mode_seen_40", 32'(mode_cnt[m] >= 40), 1);
        end_run();

        // QC stuck at 0, with Run toggled mid-run (must be ignored).
        build_obs(1);
        chk("pin_fault1_detect", 32'(pre_err[N] > 0), 1);
        tog_lo = 100; tog_hi = 110;
        do_run(1, 0);
        tog_lo = -1; tog_hi = -1;
        end_run();

        // Clean run: counters must restart from zero.
        do_run(0, 0);
        end_run();

        // SR/SL swapped chip.
        build_obs(2);
        chk("pin_fault2_detect", 32'(pre_err[N] > 0), 1);
        do_run(2, 0);
        end_run();

        // Reset during CLK_HI of vector 10, then an identical full rerun.
        do_run(0, 3 + 10 * P + 2);
        repeat (2) @(negedge Clk);
        do_run(0, 0);
        end_run();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chip_shiftreg_checker.md
Name: chip_shiftreg_checker

Overview:
Parametrised tester for universal bidirectional shift-register chips (74194 at WIDTH=4, 74299-class at WIDTH=8).
- On Run, clears the chip and applies NUM_VECTORS pseudo-random vectors across hold / shift-right / shift-left / parallel-load.
- Each vector: drives chip inputs, pulses the chip clock, then compares the chip outputs against an internal reference model.
- Reports pass/fail, error count and first-failing vector index to the board-level result display.

Parameters:
WIDTH, 4, register width in bits (2..16)
NUM_VECTORS, 64, vectors per run (1..65535)
SEED, 16'hACE1, LFSR seed, reloaded at every run start
CLK_HI_CYC, 4, Clk cycles the chip clock is held high
SETTLE_CYC, 4, Clk cycles waited after the chip clock falls, before sampling
SYNC_STAGES, 2, synchroniser flops on dut_q
CLR_EVERY, 16, chip clear is re-asserted on vectors whose index is a multiple of this; 0 disables

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
Run  in  1  level; rising edge starts a run
DISP_RSLT  in  1  gates RSLT onto display
dut_clr_n  out  1  chip CLR (active low)
dut_s  out  2  chip {S1,S0}
dut_sr  out  1  serial right input
dut_sl  out  1  serial left input
dut_par  out  WIDTH  parallel data; bit0 = A
dut_clk  out  1  chip clock
dut_q  in  WIDTH  chip outputs; bit0 = QA
Done  out  1  run complete
RSLT  out  1  pass flag, gated by DISP_RSLT
err_count  out  16  mismatching vectors, saturating at 16'hFFFF
first_fail  out  16  index of the first mismatch; 16'hFFFF if none

Behaviour:
- Reset: state IDLE, dut_clr_n=1, dut_clk=0, dut_s=0, dut_sr=0, dut_sl=0, dut_par=0, Done=0, RSLT=0, err_count=0, first_fail=16'hFFFF, model=0, vector index=0.
- Reset mid-run aborts the run immediately with the same values. Reset has priority over all other events.
- Run start: registered Run rising edge detected in IDLE only. Run edges in any other state are ignored.
- States and transitions:
  - IDLE -> CLEAR: on Run edge. Load LFSR=SEED, index=0, err_count=0, first_fail=FFFF.
  - CLEAR: dut_clr_n=0 for 2 cycles, model=0, then -> SETUP.
  - SETUP (1 cycle): drive LFSR fields. dut_s=lfsr[1:0], dut_sr=lfsr[2], dut_sl=lfsr[3], dut_par=lfsr[WIDTH+3:4], wrapped modulo 16 for WIDTH>12. If CLR_EVERY!=0 and index%CLR_EVERY==0 and index!=0, assert dut_clr_n=0 and force model=0 instead of clocking. -> CLK_HI.
  - CLK_HI: dut_clk=1 for CLK_HI_CYC cycles. The model updates once, on entry.
  - CLK_LO/SETTLE: dut_clk=0 for SETTLE_CYC+SYNC_STAGES cycles. Inputs remain stable throughout.
  - CHECK (1 cycle): compare synchronised dut_q with model.
    - On mismatch: err_count++ (saturating); if first_fail==FFFF, first_fail=index.
    - Advance the 16-bit Galois LFSR (taps 16,14,13,11); index++.
    - If index==NUM_VECTORS-1 -> DONE, else -> SETUP.
  - DONE: Done=1, dut_clr_n=1, all other chip drives 0. -> IDLE when Run is low.
- Model (q[0]=QA), per mode:
  - 00: hold.
  - 01: shift right, q[0]<=SR, q[i]<=q[i-1].
  - 10: shift left, q[W-1]<=SL, q[i]<=q[i+1].
  - 11: load, q<=par.
- Clear vectors are still compared (expected 0).
- RSLT = Done & DISP_RSLT & (err_count==0). Otherwise 0.
- err_count and first_fail hold their values through DONE and IDLE until the next run start.
- All chip-facing outputs are registered. No combinational path exists from dut_q to any output.

Test Plan:
- Behavioural 74194 model with WIDTH=4 on dut_*, Run pulse → Done after deterministic cycle count; err_count=0; RSLT=1 with DISP_RSLT=1 and 0 with DISP_RSLT=0.
- Chip model with QC stuck at 0 → err_count>0; first_fail equals the first vector where the model's q[2]=1; RSLT=0.
- WIDTH=8, NUM_VECTORS=256, 8-bit behavioural chip → err_count=0. All four modes each observed ≥40 times. Clear asserted at indices 16,32,…,240.
- Reset asserted during CLK_HI of vector 10 → next cycle IDLE, dut_clk=0, dut_clr_n=1, Done=0; a subsequent Run reruns from SEED and produces an identical dut_* trace.
- Run held high after DONE → no restart. Run toggled during a run → ignored. Run low then high → new run with counters cleared.
- Chip that swaps SR/SL → first_fail = index of the first shift vector with SR≠SL; err_count matches a software reference count.
